// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operation handshake, flush and result handshake.
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] dataOne;
    logic [XLEN-1:0] dataTwo;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            negative;
    logic            illegal;

    modport master (
        output in_valid, op, dataOne, dataTwo, flush, out_ready,
        input  in_ready, out_valid, result, zero, negative, illegal
    );

    modport slave (
        input  in_valid, op, dataOne, dataTwo, flush, out_ready,
        output in_ready, out_valid, result, zero, negative, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: integer ALU with single-cycle base ops and iterative multiply/divide.
// Base, illegal and divide fast-path results register at the accept edge; MUL and
// DIV run XLEN iterations each before registering their result.
module seq_alu #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;

    logic [2*XLEN-1:0] mcand, prod, prod_step, mul_full;
    logic [XLEN-1:0]   mplier;
    logic              m_neg, m_high;

    logic [XLEN:0]     div_rem;
    logic [XLEN-1:0]   div_quo, div_den, quo_fix, rem_fix;
    logic              q_neg, r_neg, rem_sel;
    logic [2*XLEN:0]   div_first, div_next;

    logic [XLEN-1:0]   a, b, a_mag, b_mag, res_next;
    logic [SHW-1:0]    shamt;
    logic              accept, m_op, is_div, fast, load_result, ill_next;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic              mul_last, div_last;

    // One restoring-division step: shift next dividend bit in, subtract if it fits.
    function automatic logic [2*XLEN:0] div_step(input logic [XLEN:0] rem,
                                                  input logic [XLEN-1:0] quo,
                                                  input logic [XLEN-1:0] den);
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sh   = {rem[XLEN-1:0], quo[XLEN-1]};
        diff = sh - {1'b0, den};
        if (!diff[XLEN])
            return {diff, quo[XLEN-2:0], 1'b1};
        return {sh, quo[XLEN-2:0], 1'b0};
    endfunction

    assign a            = bus.dataOne;
    assign b            = bus.dataTwo;
    assign shamt        = b[SHW-1:0];
    assign bus.in_ready = !rst && (state == IDLE) && (!bus.out_valid || bus.out_ready) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign m_op         = ENABLE_M && (bus.op[4:3] == 2'b10);
    assign is_div       = m_op && bus.op[2];
    assign mul_last     = (state == MUL) && (count == CW'(XLEN - 1));
    assign div_last     = (state == DIV) && (count == CW'(XLEN));

    // Operand sign handling and divide fast-path detection for the op being presented.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (bus.op[2]) begin
            a_signed = !bus.op[0];
            b_signed = !bus.op[0];
        end else begin
            a_signed = (bus.op[1:0] == 2'd1) || (bus.op[1:0] == 2'd2);
            b_signed = (bus.op[1:0] == 2'd1);
        end
        a_neg     = a_signed && a[XLEN-1];
        b_neg     = b_signed && b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        fast      = is_div && ((b == '0) ||
                    (!bus.op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
        div_first = div_step({(XLEN+1){1'b0}}, a_mag, b_mag);
    end

    // Result selection: iterative completions first, otherwise a single-cycle accept.
    always_comb begin
        res_next    = '0;
        ill_next    = 1'b0;
        load_result = 1'b0;
        prod_step   = prod + (mplier[0] ? mcand : '0);
        mul_full    = m_neg ? -prod_step : prod_step;
        div_next    = div_step(div_rem, div_quo, div_den);
        quo_fix     = q_neg ? -div_quo : div_quo;
        rem_fix     = r_neg ? -div_rem[XLEN-1:0] : div_rem[XLEN-1:0];
        if (mul_last) begin
            load_result = 1'b1;
            res_next    = m_high ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
        end else if (div_last) begin
            load_result = 1'b1;
            res_next    = rem_sel ? rem_fix : quo_fix;
        end else if (accept && !(m_op && !fast)) begin
            load_result = 1'b1;
            if (fast) begin
                if (b == '0)
                    res_next = bus.op[1] ? a : '1;
                else
                    res_next = bus.op[1] ? '0 : a;
            end else begin
                case (bus.op)
                    5'd0:    res_next = a + b;
                    5'd1:    res_next = a - b;
                    5'd2:    res_next = a << shamt;
                    5'd3:    res_next = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                    5'd4:    res_next = {{(XLEN-1){1'b0}}, (a < b)};
                    5'd5:    res_next = a ^ b;
                    5'd6:    res_next = a >> shamt;
                    5'd7:    res_next = $signed(a) >>> shamt;
                    5'd8:    res_next = a | b;
                    5'd9:    res_next = a & b;
                    default: ill_next = 1'b1;
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: enter MUL/DIV on an iterative accept, return to IDLE on completion or flush.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && m_op && !fast) state_next = bus.op[2] ? DIV : MUL;
            MUL:     if (mul_last) state_next = IDLE;
            DIV:     if (div_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    // Iterative multiply/divide datapath and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            m_neg   <= 1'b0;
            m_high  <= 1'b0;
            div_rem <= '0;
            div_quo <= '0;
            div_den <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            rem_sel <= 1'b0;
        end else if (bus.flush) begin
            count <= '0;
        end else if (accept && m_op && !fast) begin
            if (bus.op[2]) begin
                {div_rem, div_quo} <= div_first;
                div_den <= b_mag;
                q_neg   <= a_neg ^ b_neg;
                r_neg   <= a_neg;
                rem_sel <= bus.op[1];
                count   <= CW'(1);
            end else begin
                mcand  <= {{XLEN{1'b0}}, a_mag};
                mplier <= b_mag;
                prod   <= '0;
                m_neg  <= a_neg ^ b_neg;
                m_high <= (bus.op[1:0] != 2'd0);
                count  <= '0;
            end
        end else if (state == MUL) begin
            prod   <= prod_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= mul_last ? '0 : count + CW'(1);
        end else if (state == DIV) begin
            if (div_last) begin
                count <= '0;
            end else begin
                {div_rem, div_quo} <= div_next;
                count <= count + CW'(1);
            end
        end
    end

    // Output register: load a new result, otherwise drop out_valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.negative  <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (load_result) begin
            bus.out_valid <= 1'b1;
            bus.result    <= res_next;
            bus.zero      <= (res_next == '0);
            bus.negative  <= res_next[XLEN-1];
            bus.illegal   <= ill_next;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (XLEN=32, multiply/divide enabled).
module tb_seq_alu;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    seq_alu_if #(.XLEN(32)) bus();

    seq_alu #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dataOne  = a;
        bus.dataTwo  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Latency counts edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.result !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_result: got %h want 0", bus.result); end
        vectors++; if ({bus.zero, bus.negative, bus.illegal} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 000", {bus.zero, bus.negative, bus.illegal}); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add_wrap();
        bus.out_ready = 1'b1;
        issue(5'd0, 32'hFFFF_FFFF, 32'h1);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.result !== 32'h0) begin miscompares++; $display("[TB] FAIL add_result: got %h want 0", bus.result); end
        vectors++; if (bus.zero !== 1'b1) begin miscompares++; $display("[TB] FAIL add_zero: got %b want 1", bus.zero); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_valid_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  vop [10];
        logic [31:0] va  [10];
        logic [31:0] vb  [10];
        logic [31:0] vexp[10];
        vop  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
        va   = '{32'h5, 32'h5, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0, 32'h8000_0000, 32'h8000_0000, 32'h0F00, 32'hFF00};
        vb   = '{32'h3, 32'h7, 32'h24, 32'h1, 32'h1, 32'hFF00, 32'h4, 32'h21, 32'h00F0, 32'h0FF0};
        vexp = '{32'h8, 32'hFFFF_FFFE, 32'h10, 32'h1, 32'h0, 32'h0FF0, 32'h0800_0000, 32'hC000_0000, 32'h0FF0, 32'h0F00};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.op      = vop[i];
            bus.dataOne = va[i];
            bus.dataTwo = vb[i];
            tick();
            vectors++; if (bus.out_valid !== 1'b1 || bus.result !== vexp[i]) begin miscompares++; $display("[TB] FAIL base_op%0d: got v=%b %h want v=1 %h", vop[i], bus.out_valid, bus.result, vexp[i]); end
            vectors++; if ({bus.zero, bus.negative, bus.illegal} !== {(vexp[i] == 32'h0), vexp[i][31], 1'b0}) begin miscompares++; $display("[TB] FAIL base_flags%0d: got %b want %b", vop[i], {bus.zero, bus.negative, bus.illegal}, {(vexp[i] == 32'h0), vexp[i][31], 1'b0}); end
        end
        bus.in_valid = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        issue(5'd10, 32'h1234, 32'h5678);
        vectors++; if (bus.illegal !== 1'b1 || bus.result !== 32'h0 || bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_op10: got ill=%b %h v=%b want ill=1 0 v=1", bus.illegal, bus.result, bus.out_valid); end
        issue(5'd15, 32'hFFFF_FFFF, 32'h2);
        vectors++; if (bus.illegal !== 1'b1 || bus.result !== 32'h0) begin miscompares++; $display("[TB] FAIL illegal_op15: got ill=%b %h want ill=1 0", bus.illegal, bus.result); end
        tick();
    endtask

    task automatic test_mul();
        int lat;
        logic [4:0]  mop [4];
        logic [31:0] ma  [4];
        logic [31:0] mb  [4];
        logic [31:0] mexp[4];
        mop  = '{5'd17, 5'd19, 5'd16, 5'd18};
        ma   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFF};
        mb   = '{32'h2, 32'h2, 32'h6, 32'hFFFF_FFFF};
        mexp = '{32'hFFFF_FFFF, 32'h1, 32'd42, 32'hFFFF_FFFF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(mop[i], ma[i], mb[i]);
            wait_valid(lat);
            vectors++; if (lat != 33) begin miscompares++; $display("[TB] FAIL mul_latency_op%0d: got %0d want 33", mop[i], lat); end
            vectors++; if (bus.result !== mexp[i] || bus.illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL mul_result_op%0d: got %h ill=%b want %h ill=0", mop[i], bus.result, bus.illegal, mexp[i]); end
            tick();
        end
    endtask

    task automatic test_div_fast();
        int lat;
        logic [4:0]  dop [4];
        logic [31:0] da  [4];
        logic [31:0] db  [4];
        logic [31:0] dexp[4];
        dop  = '{5'd20, 5'd23, 5'd21, 5'd22};
        da   = '{32'h8000_0000, 32'h7, 32'h5, 32'h8000_0000};
        db   = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};
        dexp = '{32'h8000_0000, 32'h7, 32'hFFFF_FFFF, 32'h0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(dop[i], da[i], db[i]);
            wait_valid(lat);
            vectors++; if (lat != 1 || bus.result !== dexp[i]) begin miscompares++; $display("[TB] FAIL div_fast_op%0d: got lat=%0d %h want lat=1 %h", dop[i], lat, bus.result, dexp[i]); end
        end
        tick();
    endtask

    task automatic test_div_hold();
        int lat;
        logic [4:0]  dop [5];
        logic [31:0] da  [5];
        logic [31:0] db  [5];
        logic [31:0] dexp[5];
        dop  = '{5'd20, 5'd20, 5'd22, 5'd21, 5'd23};
        da   = '{32'hFFFF_FFF9, 32'h7, 32'h7, 32'd100, 32'd100};
        db   = '{32'h2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7, 32'd7};
        dexp = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h1, 32'd14, 32'd2};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(dop[i], da[i], db[i]);
            wait_valid(lat);
            vectors++; if (lat != 33 || bus.result !== dexp[i]) begin miscompares++; $display("[TB] FAIL div_op%0d_%0d: got lat=%0d %h want lat=33 %h", dop[i], i, lat, bus.result, dexp[i]); end
            tick();
        end
        bus.out_ready = 1'b0;
        issue(5'd22, 32'hFFFF_FFF9, 32'h2);
        wait_valid(lat);
        vectors++; if (lat != 33 || bus.result !== 32'hFFFF_FFFF || bus.negative !== 1'b1) begin miscompares++; $display("[TB] FAIL rem_neg: got lat=%0d %h n=%b want lat=33 ffffffff n=1", lat, bus.result, bus.negative); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFF_FFFF || bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_cycle%0d: got v=%b %h rdy=%b want v=1 ffffffff rdy=0", i, bus.out_valid, bus.result, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_release: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        int seen;
        bus.out_ready = 1'b1;
        issue(5'd21, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 5'd0;
        bus.dataOne  = 32'h1;
        bus.dataTwo  = 32'h1;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_blocks_ready: got %b want 0", bus.in_ready); end
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_idle: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_rst_abort();
        int seen;
        bus.out_ready = 1'b1;
        issue(5'd21, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_div: got rdy=%b v=%b want 0 0", bus.in_ready, bus.out_valid); end
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_ready: got %b want 1", bus.in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL rst_no_result: got %0d valid cycles want 0", seen); end
        issue(5'd31, 32'hDEAD_BEEF, 32'h1);
        vectors++; if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.result !== 32'h0) begin miscompares++; $display("[TB] FAIL op31_illegal: got v=%b ill=%b %h want v=1 ill=1 0", bus.out_valid, bus.illegal, bus.result); end
        tick();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 5'd0;
        bus.dataOne   = 32'h0;
        bus.dataTwo   = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_illegal();
        test_mul();
        test_div_fast();
        test_div_hold();
        test_flush();
        test_rst_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
